// File: rtl/cc_irq_pkg.sv
// Shared types, default parameters and helpers for the IRQ scheduler / watchdog.
package cc_irq_pkg;

  typedef enum logic {
    PULSE = 1'b0,
    RUN   = 1'b1
  } wd_state_e;

  localparam int unsigned IRQ_PERIOD_LOG2_DEF = 6;
  localparam int unsigned WDOG_FRAMES_DEF     = 16;
  localparam int unsigned RST_PULSE_DEF       = 32;

  // Increment that sticks at max; narrower counters zero-extend in and truncate out.
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] max);
    return (v == max) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cc_irq_wdog_ctrl_watchdog.sv
// Frame watchdog: vblank edge detect, starvation count and PULSE/RUN reset FSM.
module cc_watchdog
  import cc_irq_pkg::*;
#(
  parameter int unsigned WDOG_FRAMES = WDOG_FRAMES_DEF,
  parameter int unsigned RST_PULSE   = RST_PULSE_DEF
) (
  input  logic       clk,
  input  logic       RESETn,
  input  logic       vblank,
  input  logic       wdog_n,
  input  logic       wdog_disable,
  output logic       cpu_reset_n,
  output logic       run,
  output logic [3:0] wdog_fires
);

  wd_state_e  state, state_nx;
  logic       vblank_q;
  logic       rise;
  logic [7:0] pulse_cnt, pulse_cnt_nx;
  logic [7:0] wd_cnt, wd_cnt_nx;
  logic [3:0] fires_nx;

  assign rise = vblank && !vblank_q;
  assign run  = (state == RUN);

  // Next-state: count out the reset pulse, then count unkicked frames until firing.
  always_comb begin
    state_nx     = state;
    pulse_cnt_nx = pulse_cnt;
    wd_cnt_nx    = wd_cnt;
    fires_nx     = wdog_fires;
    if (state == PULSE) begin
      pulse_cnt_nx = pulse_cnt + 8'd1;
      if (pulse_cnt == 8'(RST_PULSE - 1)) begin
        state_nx  = RUN;
        wd_cnt_nx = '0;
      end
    end else begin
      if (!wdog_n || wdog_disable) begin
        wd_cnt_nx = '0;
      end else if (rise) begin
        if (wd_cnt == 8'(WDOG_FRAMES - 1)) begin
          state_nx     = PULSE;
          pulse_cnt_nx = '0;
          wd_cnt_nx    = '0;
          fires_nx     = 4'(sat_inc({4'd0, wdog_fires}, 8'd15));
        end else begin
          wd_cnt_nx = wd_cnt + 8'd1;
        end
      end
    end
  end

  // State and counters; cpu_reset_n is registered from the next state so it tracks PULSE exactly.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state       <= PULSE;
      vblank_q    <= 1'b0;
      pulse_cnt   <= '0;
      wd_cnt      <= '0;
      wdog_fires  <= '0;
      cpu_reset_n <= 1'b0;
    end else begin
      state       <= state_nx;
      vblank_q    <= vblank;
      pulse_cnt   <= pulse_cnt_nx;
      wd_cnt      <= wd_cnt_nx;
      wdog_fires  <= fires_nx;
      cpu_reset_n <= (state_nx == RUN);
    end
  end

endmodule

// File: rtl/cc_irq_wdog_ctrl.sv
// CPU IRQ scheduler at fixed scanline spacing plus frame watchdog driving CPU reset.
module cc_irq_wdog_ctrl
  import cc_irq_pkg::*;
#(
  parameter int unsigned                 IRQ_PERIOD_LOG2 = IRQ_PERIOD_LOG2_DEF,
  parameter logic [IRQ_PERIOD_LOG2-1:0]  IRQ_PHASE       = '0,
  parameter int unsigned                 WDOG_FRAMES     = WDOG_FRAMES_DEF,
  parameter int unsigned                 RST_PULSE       = RST_PULSE_DEF
) (
  input  logic       clk,
  input  logic       RESETn,
  input  logic [7:0] vcount,
  input  logic       line_start,
  input  logic       vblank,
  input  logic       intack_n,
  input  logic       wdog_n,
  input  logic       wdog_disable,
  output logic       irq_n,
  output logic       cpu_reset_n,
  output logic [7:0] irq_overrun,
  output logic [3:0] wdog_fires
);

  logic run;
  logic irq_event;
  logic unused_vcount;

  // Only the low bits select the phase; the rest of vcount is deliberately ignored.
  assign unused_vcount = ^vcount;
  assign irq_event = line_start && (vcount[IRQ_PERIOD_LOG2-1:0] == IRQ_PHASE) && run;

  cc_watchdog #(
    .WDOG_FRAMES (WDOG_FRAMES),
    .RST_PULSE   (RST_PULSE)
  ) u_wdog (
    .clk          (clk),
    .RESETn       (RESETn),
    .vblank       (vblank),
    .wdog_n       (wdog_n),
    .wdog_disable (wdog_disable),
    .cpu_reset_n  (cpu_reset_n),
    .run          (run),
    .wdog_fires   (wdog_fires)
  );

  // IRQ line: ack beats a new event, and any event that cannot become a fresh IRQ is an overrun.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      irq_n       <= 1'b1;
      irq_overrun <= '0;
    end else if (!run) begin
      irq_n <= 1'b1;
    end else if (!intack_n) begin
      irq_n <= 1'b1;
      if (irq_event) irq_overrun <= sat_inc(irq_overrun, 8'd255);
    end else if (irq_event) begin
      if (!irq_n) irq_overrun <= sat_inc(irq_overrun, 8'd255);
      irq_n <= 1'b0;
    end
  end

endmodule
